// File: rtl/stage_decode.sv
// Decode stage: IF/ID register, register file, sign extender and early beq/bne resolution.
// Optional write-through read bypass is enabled by defining DECODE_BYPASS_EN.
module stage_decode #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_F,
    input  logic [31:0]      pcplus4_F,
    input  logic             stall_D,
    input  logic             flush_D,
    input  logic             we_W,
    input  logic [4:0]       wa_W,
    input  logic [WIDTH-1:0] wd_W,
    input  logic             fwd_a_D,
    input  logic             fwd_b_D,
    input  logic [WIDTH-1:0] aluout_M,
    output logic [31:0]      instr_D,
    output logic [31:0]      pcplus4_D,
    output logic             valid_D,
    output logic [WIDTH-1:0] rd1_D,
    output logic [WIDTH-1:0] rd2_D,
    output logic [WIDTH-1:0] signimm_D,
    output logic [4:0]       rs_D,
    output logic [4:0]       rt_D,
    output logic [4:0]       rd_D,
    output logic [WIDTH-1:0] pcbranch,
    output logic             PC_SRC
);

    localparam int unsigned IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [5:0]  OP_BNE    = 6'b000101;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             taken;
    logic             wr_en;

    function automatic logic addr_ok(input logic [4:0] a);
        return 32'(a) < NREGS;
    endfunction

    // IF/ID pipeline register: reset > stall > flush/taken branch > load
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_D   <= NOP_INSTR;
            pcplus4_D <= 32'd0;
            valid_D   <= 1'b0;
        end else if (stall_D) begin
            instr_D   <= instr_D;
            pcplus4_D <= pcplus4_D;
            valid_D   <= valid_D;
        end else if (flush_D || PC_SRC) begin
            instr_D   <= NOP_INSTR;
            pcplus4_D <= 32'd0;
            valid_D   <= 1'b0;
        end else begin
            instr_D   <= instr_F;
            pcplus4_D <= pcplus4_F;
            valid_D   <= 1'b1;
        end
    end

    assign wr_en = we_W && (wa_W != 5'd0) && addr_ok(wa_W);

    // Register file; r0 and out-of-range addresses are never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[IDX_W'(wa_W)] <= wd_W;
        end
    end

    assign rs_D = instr_D[25:21];
    assign rt_D = instr_D[20:16];
    assign rd_D = instr_D[15:11];

    // Combinational reads, optionally bypassing the same-cycle writeback
    always_comb begin
        rd1_D = '0;
        rd2_D = '0;
        if (addr_ok(rs_D)) begin
            rd1_D = regs[IDX_W'(rs_D)];
        end
        if (addr_ok(rt_D)) begin
            rd2_D = regs[IDX_W'(rt_D)];
        end
`ifdef DECODE_BYPASS_EN
        if (we_W && (wa_W != 5'd0) && (wa_W == rs_D)) begin
            rd1_D = wd_W;
        end
        if (we_W && (wa_W != 5'd0) && (wa_W == rt_D)) begin
            rd2_D = wd_W;
        end
`endif
    end

    assign signimm_D = WIDTH'($signed(instr_D[15:0]));
    assign pcbranch  = WIDTH'(pcplus4_D) + (signimm_D << 2);

    assign op_a = fwd_a_D ? aluout_M : rd1_D;
    assign op_b = fwd_b_D ? aluout_M : rd2_D;

    // Early branch resolution; a stalled slot never redirects fetch
    always_comb begin
        taken = 1'b0;
        case (instr_D[31:26])
            OP_BEQ:  taken = (op_a == op_b);
            OP_BNE:  taken = (op_a != op_b);
            default: taken = 1'b0;
        endcase
    end

    assign PC_SRC = taken && valid_D && !stall_D;

endmodule

// File: doc/stage_decode.md
# stage_decode

Decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage. It holds the IF/ID pipeline register (with stall and flush), the 32-entry register file, and the sign extender. It resolves `beq`/`bne` early in decode and returns `pcbranch` and `PC_SRC` to the fetch stage's next-PC mux.

## Interface
- `WIDTH`, 32, datapath width.
- `NREGS`, 32, register-file depth; the address width is fixed at 5.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `instr_F`  in  32  instruction from fetch.
- `pcplus4_F`  in  32  PC+4 from fetch.
- `stall_D`  in  1  hazard unit: hold IF/ID and suppress the branch decision.
- `flush_D`  in  1  hazard unit: clear IF/ID (external kill).
- `we_W`  in  1  writeback enable.
- `wa_W`  in  5  writeback register address.
- `wd_W`  in  WIDTH  writeback data.
- `fwd_a_D`, `fwd_b_D`  in  1 each  select `aluout_M` for the branch-compare operands.
- `aluout_M`  in  WIDTH  MEM-stage ALU result, used for branch forwarding.
- `instr_D`  out  32  registered instruction.
- `pcplus4_D`  out  32  registered PC+4.
- `valid_D`  out  1  slot holds a real instruction.
- `rd1_D`, `rd2_D`  out  WIDTH  register-file reads of `rs` and `rt`.
- `signimm_D`  out  WIDTH  sign-extended immediate.
- `rs_D`, `rt_D`, `rd_D`  out  5 each  fields `instr_D[25:21]`, `[20:16]`, `[15:11]`.
- `pcbranch`  out  WIDTH  branch target to fetch.
- `PC_SRC`  out  1  take `pcbranch` at the next edge.

## Operation
- **Reset**
  - IF/ID clears: `instr_D`=0 (sll $0 = nop), `pcplus4_D`=0, `valid_D`=0.
  - All register-file entries clear to 0.
  - As a result `PC_SRC`=0, `pcbranch`=0, `rd1_D`=`rd2_D`=0 and `signimm_D`=0.
- **IF/ID update.** Each edge, in priority order:
  1. `reset`: clear as above.
  2. `stall_D`: hold all fields.
  3. `flush_D` or `PC_SRC`: load nop, `valid_D`=0. A taken branch kills the wrong-path instruction; there is no delay slot.
  4. Otherwise: load `instr_F`, `pcplus4_F`, and set `valid_D`=1.
- **Register file**
  - Write at the edge when `we_W` is set and `wa_W`≠0.
  - Writes to r0 are dropped, so r0 always reads 0.
  - Reads are combinational on `rs_D`/`rt_D`.
- **Immediate.** `signimm_D` = `{{16{instr_D[15]}}, instr_D[15:0]}`.
- **Branch operands**
  - `a` = `fwd_a_D` ? `aluout_M` : `rd1_D`.
  - `b` = `fwd_b_D` ? `aluout_M` : `rd2_D`.
- **Branch decision**
  - `beq` is opcode 6'b000100; `bne` is opcode 6'b000101.
  - `taken` = (`beq` & `a`==`b`) | (`bne` & `a`≠`b`).
  - `PC_SRC` = `taken` & `valid_D` & ~`stall_D`.
- **Branch target**
  - `pcbranch` = `pcplus4_D` + (`signimm_D`<<2).
  - The add is mod 2^32 and wraps silently.
  - `pcbranch` is driven every cycle regardless of `PC_SRC`.
- **Out-of-range addresses.** If `NREGS`<32, writes to addresses ≥`NREGS` are dropped and reads from them return 0.

## Timing
- IF/ID latency is 1 cycle: `instr_F` present at edge N appears on `instr_D` during cycle N+1.
- The branch decision is combinational within the decode cycle. Fetch's PC register samples `pcbranch` at the next edge.
- A taken branch costs one bubble: the instruction fetched behind the branch is flushed at that same edge.
- `stall_D` together with a branch: `PC_SRC` is held at 0 while stalled. The decision re-evaluates once the stall drops.
- `stall_D` together with `flush_D`: stall wins and the slot is held.
- Reset asserted mid-operation: cleared at the next edge regardless of stall or flush. Any pending branch is lost.

## Configuration
- **`DECODE_BYPASS_EN` defined:** write-through bypass.
  - If `we_W` & `wa_W`≠0 & `wa_W`==`rs_D`, then `rd1_D`=`wd_W` in the same cycle. `rt_D` and `rd2_D` behave the same way.
  - This gives a 0-cycle write-to-read path.
- **`DECODE_BYPASS_EN` undefined:**
  - Reads return the pre-edge array contents.
  - A value written at edge N is readable from cycle N+1.
  - The hazard unit must cover the extra cycle.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles, then release. Require `instr_D`=0, `valid_D`=0, `PC_SRC`=0, and every register reading 0.
- **Write/read, r0 protection:**
  - Write r5=0xDEADBEEF, then read r5 → 0xDEADBEEF.
  - Write r0=0x1234, then read r0 → 0.
- **Taken `beq`:**
  - Setup: r1=r2=7, `instr_F`=0x10220003, `pcplus4_F`=0x104.
  - Next cycle: `PC_SRC`=1 and `pcbranch`=0x110. The following edge loads a nop with `valid_D`=0.
  - Repeat as `bne` (0x14220003) → `PC_SRC`=0.
- **Stall:**
  - Assert `stall_D` for 3 cycles during a taken branch.
  - `instr_D` is unchanged and `PC_SRC`=0 throughout. After release, `PC_SRC`=1 for exactly one cycle.
- **Forwarding:**
  - Setup: r1=3, r2=9, `fwd_a_D`=1, `aluout_M`=9, `beq` r1,r2 → `PC_SRC`=1.
  - With `fwd_a_D`=0 → `PC_SRC`=0.
- **Bypass:**
  - Same-cycle write r3=0xA5A5A5A5 while `rs_D`=3.
  - With `DECODE_BYPASS_EN`: `rd1_D`=0xA5A5A5A5 in that cycle.
  - Without it: old value that cycle, new value in the next cycle.
